// File: rtl/cut_position_queue_pkg.sv
// cut_queue_pkg: shared state encoding and defaults for cut_position_queue.
// Revision 1.0
`default_nettype none

package cut_queue_pkg;

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    VBLANK    = 2'd1,
    ACTIVE    = 2'd2
  } cq_state_e;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 16;

  localparam logic [DEFAULT_DATA_WIDTH-1:0] IDENTITY_CUT = '0;

endpackage

`default_nettype wire

// File: rtl/cut_position_queue_sync_fifo.sv
// sync_fifo: circular storage with occupancy count; flush empties it before a same-cycle push.
// Revision 1.0
`default_nettype none

module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_push,
  input  logic                          i_pop,
  input  logic                          i_flush,
  input  logic [DATA_WIDTH-1:0]         i_data,
  output logic [DATA_WIDTH-1:0]         o_head,
  output logic                          o_empty,
  output logic                          o_full,
  output logic [$clog2(DEPTH):0]        o_level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W:0]        r_level;
  logic                  w_push_ok;
  logic                  w_pop_ok;

  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == (PTR_W+1)'(DEPTH));
  assign o_head  = r_mem[r_rd_ptr];
  assign o_level = r_level;

  // A flush frees every slot, so a coincident push is always accepted.
  assign w_push_ok = i_push && (i_flush || !o_full);
  assign w_pop_ok  = i_pop && !o_empty && !i_flush;

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (i_flush) begin
        r_rd_ptr <= r_wr_ptr;
        r_level  <= (PTR_W+1)'(w_push_ok);
      end else begin
        if (w_pop_ok) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
        r_level <= r_level + (PTR_W+1)'(w_push_ok) - (PTR_W+1)'(w_pop_ok);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cut_position_queue.sv
// cut_position_queue: per-line cut position buffer, flushed at field start.
// Revision 1.0. Optional CUT_QUEUE_STATS_EN adds saturating underflow/overflow event counters.
`default_nettype none

module cut_position_queue
  import cut_queue_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  in_ready,
  input  logic                  H,
  input  logic                  V,
  output logic [DATA_WIDTH-1:0] cut_position,
  output logic                  cut_position_valid,
  output logic [PTR_W:0]        level,
  output logic                  underflow,
  output logic                  overflow
`ifdef CUT_QUEUE_STATS_EN
  ,
  output logic [15:0]           underflow_count,
  output logic [15:0]           overflow_count
`endif
);

  cq_state_e             r_state;
  logic                  r_prev_h;
  logic                  r_prev_v;
  logic                  w_h_rise;
  logic                  w_v_rise;
  logic                  w_flush;
  logic                  w_pop;
  logic                  w_empty;
  logic                  w_full;
  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_underflow_ev;
  logic                  w_overflow_ev;

  assign w_h_rise = H & ~r_prev_h;
  assign w_v_rise = V & ~r_prev_v;
  assign w_flush  = w_v_rise && (r_state != VBLANK);
  assign w_pop    = (r_state == ACTIVE) && w_h_rise && !w_flush;

  assign w_underflow_ev = w_pop && w_empty;
  assign w_overflow_ev  = data_in_valid && w_full && !w_flush;
  assign in_ready       = !w_full;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (data_in_valid),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (data_in),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_level (level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state            <= SYNC_WAIT;
      r_prev_h           <= 1'b1;
      r_prev_v           <= 1'b1;
      cut_position       <= '0;
      cut_position_valid <= 1'b0;
      underflow          <= 1'b0;
      overflow           <= 1'b0;
    end else begin
      r_prev_h <= H;
      r_prev_v <= V;
      case (r_state)
        SYNC_WAIT: if (w_v_rise) r_state <= VBLANK;
        VBLANK:    if (!V)       r_state <= ACTIVE;
        ACTIVE:    if (w_v_rise) r_state <= VBLANK;
        default:                 r_state <= SYNC_WAIT;
      endcase
      if (w_flush) begin
        cut_position_valid <= 1'b0;
      end
      // An empty pop substitutes the identity rotation instead of reusing a stale value.
      if (w_pop) begin
        if (w_empty) begin
          cut_position       <= DATA_WIDTH'(IDENTITY_CUT);
          cut_position_valid <= 1'b0;
        end else begin
          cut_position       <= w_head;
          cut_position_valid <= 1'b1;
        end
      end
      if (w_underflow_ev) underflow <= 1'b1;
      if (w_overflow_ev)  overflow  <= 1'b1;
    end
  end

`ifdef CUT_QUEUE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      underflow_count <= '0;
      overflow_count  <= '0;
    end else begin
      if (w_underflow_ev && (underflow_count != 16'hFFFF)) underflow_count <= underflow_count + 16'd1;
      if (w_overflow_ev && (overflow_count != 16'hFFFF))   overflow_count  <= overflow_count + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_cut_position_queue.sv
// tb_cut_position_queue: randomized + directed stimulus against a queue-based reference model.
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_cut_position_queue;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int PW    = 4;

  localparam int ST_SYNC = 0;
  localparam int ST_VB   = 1;
  localparam int ST_ACT  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] data_in;
  logic          data_in_valid;
  logic          in_ready;
  logic          H;
  logic          V;
  logic [DW-1:0] cut_position;
  logic          cut_position_valid;
  logic [PW:0]   level;
  logic          underflow;
  logic          overflow;
`ifdef CUT_QUEUE_STATS_EN
  logic [15:0]   underflow_count;
  logic [15:0]   overflow_count;
`endif

  cut_position_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk                (clk),
    .reset              (reset),
    .data_in            (data_in),
    .data_in_valid      (data_in_valid),
    .in_ready           (in_ready),
    .H                  (H),
    .V                  (V),
    .cut_position       (cut_position),
    .cut_position_valid (cut_position_valid),
    .level              (level),
    .underflow          (underflow),
    .overflow           (overflow)
`ifdef CUT_QUEUE_STATS_EN
    ,
    .underflow_count    (underflow_count),
    .overflow_count     (overflow_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cut;
    bit         valid;
    bit         uf;
    bit         of;
    bit         rdy;
    int         lvl;
    int         ufc;
    int         ofc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: a byte queue plus the field state.
  byte unsigned mq[$];
  int           m_st;
  bit           m_ph, m_pv;
  logic [7:0]   m_cut;
  bit           m_valid, m_uf, m_of;
  int           m_ufc, m_ofc;

  task automatic model_step(input bit rst, input logic [7:0] d, input bit dv, input bit h, input bit v);
    bit   hr, vr, fl, pp;
    int   sz;
    exp_t e;
    if (rst) begin
      mq.delete();
      m_st = ST_SYNC; m_ph = 1; m_pv = 1;
      m_cut = 8'h00; m_valid = 0; m_uf = 0; m_of = 0;
      m_ufc = 0; m_ofc = 0;
    end else begin
      hr = h && !m_ph;
      vr = v && !m_pv;
      fl = vr && (m_st != ST_VB);
      pp = (m_st == ST_ACT) && hr && !fl;
      sz = mq.size();
      if (fl) begin
        mq.delete();
        m_valid = 0;
      end
      if (pp) begin
        if (sz == 0) begin
          m_cut = 8'h00; m_valid = 0; m_uf = 1;
          if (m_ufc < 65535) m_ufc++;
        end else begin
          m_cut = mq.pop_front(); m_valid = 1;
        end
      end
      if (dv) begin
        if (!fl && sz == DEPTH) begin
          m_of = 1;
          if (m_ofc < 65535) m_ofc++;
        end else begin
          mq.push_back(d);
        end
      end
      if (m_st == ST_SYNC && vr)      m_st = ST_VB;
      else if (m_st == ST_VB && !v)   m_st = ST_ACT;
      else if (m_st == ST_ACT && vr)  m_st = ST_VB;
      m_ph = h; m_pv = v;
    end
    e.cut = m_cut; e.valid = m_valid; e.uf = m_uf; e.of = m_of;
    e.lvl = mq.size(); e.rdy = (mq.size() != DEPTH);
    e.ufc = m_ufc; e.ofc = m_ofc;
    exp_q.push_back(e);
  endtask

  task automatic step(input bit rst, input logic [7:0] d, input bit dv, input bit h, input bit v);
    @(negedge clk);
    reset = rst; data_in = d; data_in_valid = dv; H = h; V = v;
    model_step(rst, d, dv, h, v);
  endtask

  task automatic push_byte(input logic [7:0] d);
    step(0, d, 1, 0, 0);
  endtask

  task automatic hpulse();
    step(0, 8'h00, 0, 1, 0);
    repeat (3) step(0, 8'h00, 0, 0, 0);
  endtask

  task automatic do_reset();
    repeat (2) step(1, 8'h00, 0, 1, 1);
  endtask

  task automatic new_field();
    step(0, 8'h00, 0, 0, 0);
    repeat (2) step(0, 8'h00, 0, 0, 1);
    repeat (2) step(0, 8'h00, 0, 0, 0);
  endtask

  // Monitor: compares every registered output one cycle after the stimulus that caused it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (cut_position !== e.cut || cut_position_valid !== e.valid) begin
          errors++;
          $display("FAIL pop_out t=%0t got cut=%02h valid=%0b want cut=%02h valid=%0b",
                   $time, cut_position, cut_position_valid, e.cut, e.valid);
        end
        checks++;
        if (int'(level) != e.lvl || in_ready !== e.rdy || underflow !== e.uf || overflow !== e.of) begin
          errors++;
          $display("FAIL status t=%0t got lvl=%0d rdy=%0b uf=%0b of=%0b want lvl=%0d rdy=%0b uf=%0b of=%0b",
                   $time, level, in_ready, underflow, overflow, e.lvl, e.rdy, e.uf, e.of);
        end
`ifdef CUT_QUEUE_STATS_EN
        checks++;
        if (int'(underflow_count) != e.ufc || int'(overflow_count) != e.ofc) begin
          errors++;
          $display("FAIL stats t=%0t got ufc=%0d ofc=%0d want ufc=%0d ofc=%0d",
                   $time, underflow_count, overflow_count, e.ufc, e.ofc);
        end
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    reset = 1; data_in = '0; data_in_valid = 0; H = 1; V = 1;
    do_reset();

    // Bytes pushed before the field start are discarded by the flush.
    step(0, 8'h00, 0, 0, 0);
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    new_field();
    repeat (3) hpulse();

    do_reset();
    new_field();
    push_byte(8'hA5); push_byte(8'h3C);
    repeat (2) hpulse();

    // Overflow: the 17th byte must never appear.
    for (int i = 0; i < 17; i++) push_byte(8'(8'h40 + i));
    repeat (17) hpulse();

    // Push coincident with pop at empty: underflow now, byte next line.
    step(0, 8'h7E, 1, 1, 0);
    repeat (3) step(0, 8'h00, 0, 0, 0);
    hpulse();

    for (int i = 0; i < 5; i++) push_byte(8'(8'hC0 + i));
    step(0, 8'h9D, 1, 0, 1);
    step(0, 8'h00, 0, 0, 1);
    repeat (2) step(0, 8'h00, 0, 0, 0);
    hpulse();

    // Mid-field reset: no pops until the next field start.
    push_byte(8'h5A);
    do_reset();
    step(0, 8'h00, 0, 0, 0);
    push_byte(8'h6B);
    repeat (2) hpulse();

    for (int ph = 0; ph < 3; ph++) begin
      for (int n = 0; n < 1500; n++) begin
        bit r, dv, h, v;
        r  = ($urandom_range(0, 499) == 0);
        dv = (ph == 0) ? ($urandom_range(0, 1) == 1) : (ph == 1) ? ($urandom_range(0, 7) == 0) : 1'b1;
        h  = ($urandom_range(0, 5) == 0);
        v  = ($urandom_range(0, 79) == 0);
        step(r, 8'($urandom), dv, h, v);
      end
    end

    step(0, 8'h00, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got pending=%0d want pending=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
